// File: rtl/sram_ctrl_pkg.sv
// Shared constants, FSM state type and request payload for the 1RW SRAM port controller.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_DATA_W     = 32;
    localparam int unsigned SRAM_ADDR_W     = 9;
    localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_W / 8;
    localparam int unsigned SRAM_DEPTH      = 1 << SRAM_ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic                       we;
        logic [SRAM_NUM_WMASKS-1:0] wmask;
        logic [SRAM_ADDR_W-1:0]     addr;
        logic [SRAM_DATA_W-1:0]     wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry read-response FIFO; head word is held in a register so rdata is a flop output.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q;
    logic                  do_push;
    logic                  do_pop;

    // Next head/tail/count from the push/pop combination.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == '0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                if (count_q != CNT_W'(1)) begin
                    head_d = tail_q;
                end
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                if (count_q == CNT_W'(1)) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign valid = valid_q;
    assign rdata = head_q;
    assign count = count_q;

endmodule

// File: rtl/sram_1rw_port_ctrl.sv
// Initiator-side controller for the OpenRAM 32x512 1RW port 0.
// Turns a valid/ready request stream into registered single-cycle macro commands,
// captures dout0 on the edge after the macro's read sample edge, and returns data
// through a 2-entry response FIFO guarded by a read-credit count.
// Optional feature macro: SRAM_CTRL_ZERO_INIT_EN (zero-fills the array after reset).
module sram_1rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
    parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OUT_W = CNT_W + 1;
`ifdef SRAM_CTRL_ZERO_INIT_EN
    localparam int unsigned RAM_DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned INIT_W      = ADDR_WIDTH + 1;
    localparam ctrl_state_e RESET_STATE = ST_INIT;
`else
    localparam ctrl_state_e RESET_STATE = ST_RUN;
`endif

    ctrl_state_e           state_q, state_d;
`ifdef SRAM_CTRL_ZERO_INIT_EN
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
`endif
    sram_req_t             req;
    logic                  req_fire;
    logic                  csb_d;
    logic                  web_d;
    logic [NUM_WMASKS-1:0] wmask_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic                  rd_cmd_q, rd_cmd_d;
    logic                  rd_dout_q;
    logic                  rsp_pop;
    logic [CNT_W-1:0]      fifo_count;
    logic [OUT_W-1:0]      occ_d;
    logic [OUT_W-1:0]      outstanding_d;
    logic                  ready_d;
    logic                  busy_d;

    assign req      = '{we: req_we, wmask: req_wmask, addr: req_addr, wdata: req_wdata};
    assign req_fire = req_valid && req_ready;
    assign rsp_pop  = rsp_valid && rsp_ready;

    // State register (and zero-fill address counter when present).
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
`ifdef SRAM_CTRL_ZERO_INIT_EN
            init_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
`ifdef SRAM_CTRL_ZERO_INIT_EN
            init_cnt_q <= init_cnt_d;
`endif
        end
    end

    // Next state, next macro command, read-credit and busy evaluation.
    always_comb begin
        state_d  = state_q;
`ifdef SRAM_CTRL_ZERO_INIT_EN
        init_cnt_d = init_cnt_q;
`endif
        csb_d    = 1'b1;
        web_d    = web0;
        wmask_d  = wmask0;
        addr_d   = addr0;
        din_d    = din0;
        rd_cmd_d = 1'b0;

        case (state_q)
`ifdef SRAM_CTRL_ZERO_INIT_EN
            ST_INIT: begin
                csb_d      = 1'b0;
                web_d      = 1'b0;
                wmask_d    = '1;
                addr_d     = init_cnt_q[ADDR_WIDTH-1:0];
                din_d      = '0;
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_W'(RAM_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (req_fire) begin
                    csb_d    = 1'b0;
                    web_d    = !req.we;
                    wmask_d  = req.wmask;
                    addr_d   = req.addr;
                    din_d    = req.wdata;
                    rd_cmd_d = !req.we;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reads that will be on the bus, at the dout0 capture point, or buffered after this edge.
        occ_d         = OUT_W'(fifo_count) + OUT_W'(rd_dout_q) - OUT_W'(rsp_pop);
        outstanding_d = occ_d + OUT_W'(rd_cmd_d) + OUT_W'(rd_cmd_q);
        ready_d       = (state_d == ST_RUN) && (outstanding_d < OUT_W'(RSP_DEPTH));
        busy_d        = (state_d != ST_RUN) || (outstanding_d != '0);
    end

    // Macro command flops, read tag pipeline and handshake outputs.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            csb0      <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            addr0     <= '0;
            din0      <= '0;
            rd_cmd_q  <= 1'b0;
            rd_dout_q <= 1'b0;
            req_ready <= 1'b0;
            busy      <= (RESET_STATE != ST_RUN);
        end else begin
            csb0      <= csb_d;
            web0      <= web_d;
            wmask0    <= wmask_d;
            addr0     <= addr_d;
            din0      <= din_d;
            rd_cmd_q  <= rd_cmd_d;
            rd_dout_q <= rd_cmd_q;
            req_ready <= ready_d;
            busy      <= busy_d;
        end
    end

    // Response buffer; dout0 is pushed only on the edge after the macro's read sample.
    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rsp_fifo (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .push      (rd_dout_q),
        .push_data (dout0),
        .pop       (rsp_pop),
        .valid     (rsp_valid),
        .rdata     (rsp_rdata),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Bench for sram_1rw_port_ctrl: behavioural OpenRAM port model, reference memory and
// in-order expected-response queue, directed steps followed by randomized traffic.
module tb_sram_1rw_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int NM = 4;
    localparam int DEPTH = 512;

    logic          clk0 = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [NM-1:0] req_wmask = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          csb0;
    logic          web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0 = 'x;

    int            n_checks = 0;
    int            n_fail = 0;
    bit            rnd_rsp = 1'b0;
    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q   [$];

    always #5 clk0 = ~clk0;

    sram_1rw_port_ctrl dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0)
    );

    // Macro model: samples the command at posedge, read data valid for one cycle then X,
    // masked write lands on the following negedge.
    always @(posedge clk0) begin : macro_model
        logic          s_rd;
        logic          s_wr;
        logic [AW-1:0] s_a;
        logic [DW-1:0] s_d;
        logic [NM-1:0] s_m;
        s_rd = (csb0 === 1'b0) && (web0 === 1'b1);
        s_wr = (csb0 === 1'b0) && (web0 === 1'b0);
        s_a  = addr0;
        s_d  = din0;
        s_m  = wmask0;
        #1;
        dout0 = s_rd ? mem[s_a] : 'x;
        if (s_wr) begin
            @(negedge clk0);
            for (int b = 0; b < NM; b++) begin
                if (s_m[b]) mem[s_a][8*b +: 8] = s_d[8*b +: 8];
            end
        end
    end

    // Reference model and response scoreboard, sampled mid-cycle.
    always @(negedge clk0) begin : scoreboard
        logic [DW-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL rsp_unexpected observed=%h expected=no response", rsp_rdata);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    assert (rsp_rdata === e) else begin
                        n_fail++;
                        $error("FAIL rsp_data observed=%h expected=%h", rsp_rdata, e);
                    end
                end
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                if (req_we) begin
                    for (int b = 0; b < NM; b++) begin
                        if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic we, input logic [NM-1:0] m, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (rnd_rsp) rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk0);
            done = (req_ready === 1'b1);
            @(posedge clk0);
            #1;
        end
        req_valid = 1'b0;
        check("req_accept", 64'(done), 64'd1);
    endtask

    task automatic wait_rsp(input string tag, input logic [DW-1:0] expv);
        bit            seen = 1'b0;
        logic [DW-1:0] got = 'x;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk0);
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                got  = rsp_rdata;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check(tag, 64'(got), 64'(expv));
        @(posedge clk0);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 500 && (exp_q.size() != 0); i++) begin
            @(posedge clk0);
            #1;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk0);
        @(negedge clk0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_csb0", 64'(csb0), 64'd1);
        check("rst_web0", 64'(web0), 64'd1);
        check("rst_cmd_fields", 64'({wmask0, addr0, din0}), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk0);
        #1;
        rst_n = 1'b1;
`ifdef SRAM_CTRL_ZERO_INIT_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk0);
            check("init_ready_busy", 64'({req_ready, busy}), 64'b01);
        end
`else
        @(negedge clk0);
        check("post_rst_ready_low", 64'(req_ready), 64'd0);
`endif
        @(negedge clk0);
        check("ready_up", 64'(req_ready), 64'd1);
        check("busy_idle_after_rst", 64'(busy), 64'd0);
        @(posedge clk0);
        #1;
    endtask

    function automatic logic [DW-1:0] post_reset_exp(input int a);
`ifdef SRAM_CTRL_ZERO_INIT_EN
        post_reset_exp = 32'h0000_0000;
`else
        post_reset_exp = ref_mem[a];
`endif
    endfunction

    initial begin : stimulus
        int            acc;
        logic          v0, v1, v2;
        logic [DW-1:0] d2;
        logic [DW-1:0] head;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end

        do_reset();
        rsp_ready = 1'b1;

        // Write then read-after-write on the next cycle, with latency check.
        send(1'b1, 4'hF, 9'h010, 32'hDEAD_BEEF);
        send(1'b0, 4'h0, 9'h010, 32'h0);
        @(negedge clk0); v0 = rsp_valid;
        @(negedge clk0); v1 = rsp_valid;
        @(negedge clk0); v2 = rsp_valid; d2 = rsp_rdata;
        check("lat_edge1", 64'(v0), 64'd0);
        check("lat_edge2", 64'(v1), 64'd0);
        check("lat_edge3", 64'(v2), 64'd1);
        check("raw_data", 64'(d2), 64'hDEAD_BEEF);
        @(posedge clk0); #1;

        // Byte-lane merge and the all-zero mask write.
        send(1'b1, 4'hF, 9'd5, 32'hAABB_CCDD);
        send(1'b1, 4'b0101, 9'd5, 32'h1122_3344);
        send(1'b0, 4'h0, 9'd5, 32'h0);
        wait_rsp("mask_merge", 32'hAA22_CC44);
        send(1'b1, 4'h0, 9'd5, $urandom);
        send(1'b0, 4'h0, 9'd5, 32'h0);
        wait_rsp("mask_zero", 32'hAA22_CC44);

        // Back-to-back reads of 0..7 with the response side always ready.
        for (int a = 0; a < 8; a++) send(1'b0, 4'h0, 9'(a), 32'h0);
        drain("b2b_drain");
        @(negedge clk0);
        check("busy_idle", 64'(busy), 64'd0);
        @(posedge clk0); #1;

        // Credit limit with the response side stalled.
        rsp_ready = 1'b0;
        acc       = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'd40;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk0);
            if (req_ready === 1'b1) acc++;
            @(posedge clk0);
            #1;
            req_addr = 9'(40 + acc);
            if (acc >= 4) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("credit_accepts", 64'(acc), 64'd2);
        head = (exp_q.size() != 0) ? exp_q[0] : 'x;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk0);
            check("credit_ready_low", 64'(req_ready), 64'd0);
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_head", 64'(rsp_rdata), 64'(head));
        end
        @(posedge clk0); #1;
        rsp_ready = 1'b1;
        for (int a = acc; a < 4; a++) send(1'b0, 4'h0, 9'(40 + a), 32'h0);
        drain("credit_drain");

        // Randomized mixed traffic on a small address window with random backpressure.
        rnd_rsp = 1'b1;
        for (int n = 0; n < 150; n++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                rsp_ready = 1'($urandom_range(0, 1));
                @(posedge clk0); #1;
            end
        end
        rnd_rsp   = 1'b0;
        rsp_ready = 1'b1;
        drain("rand_drain");

        // Reset with two reads in flight; nothing stale may come out afterwards.
        send(1'b0, 4'h0, 9'd20, 32'h0);
        send(1'b0, 4'h0, 9'd21, 32'h0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk0);
            check("no_stale_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk0); #1;

        // Post-reset contents at the array boundaries and midpoint.
        send(1'b0, 4'h0, 9'd0, 32'h0);
        wait_rsp("post_rst_rd0", post_reset_exp(0));
        send(1'b0, 4'h0, 9'd255, 32'h0);
        wait_rsp("post_rst_rd255", post_reset_exp(255));
        send(1'b0, 4'h0, 9'd511, 32'h0);
        wait_rsp("post_rst_rd511", post_reset_exp(511));
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
